// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, error codes, word width.
package imem_loader_pkg;

  localparam int INSTR_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_HI,
    ST_LEN_LO,
    ST_DATA,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } ld_state_t;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CSUM = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;

endpackage

// File: rtl/imem_word_packer.sv
// Big-endian byte-to-word packer; word_vld fires combinationally with the last byte of each word.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int WORD_BYTES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clr,
  input  logic               byte_vld,
  input  logic [7:0]         byte_in,
  output logic               word_vld,
  output logic [INSTR_W-1:0] word
);

  logic [1:0]  cnt_p0;
  logic [23:0] sh_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_p0 <= 2'd0;
    end else if (clr) begin
      cnt_p0 <= 2'd0;
    end else if (byte_vld) begin
      cnt_p0 <= cnt_p0 + 2'd1;
    end
  end

  // Shift register holds the three earlier bytes; the fourth is taken straight from the input.
  always_ff @(posedge clk) begin
    if (byte_vld) begin
      sh_p0 <= {sh_p0[15:0], byte_in};
    end
  end

  assign word_vld = byte_vld && (cnt_p0 == 2'(WORD_BYTES - 1));
  assign word     = {sh_p0, byte_in};

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed byte stream into instruction memory; holds the CPU until it verifies.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int WORD_BYTES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic               rx_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic [1:0]         err
);

  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_W);

  ld_state_t          state;
  logic [7:0]         len_hi;
  logic [15:0]        len;
  logic [16:0]        wcnt;
  logic [7:0]         acc;
  logic               hs;
  logic               idle_like;
  logic [15:0]        n_in;
  logic               word_vld;
  logic [INSTR_W-1:0] word;

  assign hs        = rx_valid && rx_ready;
  assign idle_like = (state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR);
  assign n_in      = {len_hi, rx_data};

  imem_word_packer #(
    .WORD_BYTES(WORD_BYTES)
  ) u_packer (
    .clk     (clk),
    .reset   (reset),
    .clr     (start && idle_like),
    .byte_vld(hs && (state == ST_DATA)),
    .byte_in (rx_data),
    .word_vld(word_vld),
    .word    (word)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      rx_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= ERR_NONE;
      len_hi     <= 8'd0;
      len        <= 16'd0;
      wcnt       <= 17'd0;
      acc        <= 8'd0;
    end else begin
      imem_we <= 1'b0;
      if (hs && (state != ST_CSUM)) begin
        acc <= acc ^ rx_data;
      end
      case (state)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start) begin
            state    <= ST_LEN_HI;
            rx_ready <= 1'b1;
            cpu_hold <= 1'b1;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= ERR_NONE;
            len      <= 16'd0;
            wcnt     <= 17'd0;
            acc      <= 8'd0;
          end
        end
        ST_LEN_HI: begin
          if (hs) begin
            len_hi <= rx_data;
            state  <= ST_LEN_LO;
          end
        end
        ST_LEN_LO: begin
          if (hs) begin
            len <= n_in;
            // Length is vetted before any write, so the word index can never wrap.
            if ({1'b0, n_in} > MAX_WORDS) begin
              state    <= ST_ERR;
              err      <= ERR_LEN;
              busy     <= 1'b0;
              rx_ready <= 1'b0;
            end else if (n_in == 16'd0) begin
              state <= ST_CSUM;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (word_vld) begin
            imem_we    <= 1'b1;
            imem_addr  <= wcnt[ADDR_W-1:0];
            imem_wdata <= word;
            wcnt       <= wcnt + 17'd1;
            if ((wcnt + 17'd1) == {1'b0, len}) begin
              state <= ST_CSUM;
            end
          end
        end
        ST_CSUM: begin
          if (hs) begin
            rx_ready <= 1'b0;
            busy     <= 1'b0;
            if (rx_data == acc) begin
              state    <= ST_DONE;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= ST_ERR;
              err   <= ERR_CSUM;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at stimulus time, popped by a write monitor.
module tb_imem_loader;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic [1:0]        err;

  int vectors = 0;
  int miscompares = 0;
  logic [39:0] exp_q[$];
  logic [7:0]  stim[$];

  imem_loader #(.ADDR_W(ADDR_W), .WORD_BYTES(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [39:0] e;
    if (reset && imem_we) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write", imem_addr, imem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 32'(imem_addr), 32'(e[39:32]));
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int maxgap);
    bit rdy;
    int t;
    t = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    forever begin
      rdy = rx_ready;
      @(posedge clk);
      if (rdy) break;
      t++;
      if (t > 100) begin
        vectors++;
        miscompares++;
        $display("FAIL handshake_timeout: got no rx_ready for byte %0h expected rx_ready=1", b);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
  endtask

  task automatic send_all(input int maxgap, input bit mid_start);
    for (int i = 0; i < stim.size(); i++) begin
      send_byte(stim[i], maxgap);
      if (mid_start && i == 5) pulse_start();
    end
  endtask

  task automatic set_normal(input logic [7:0] csum);
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, csum};
  endtask

  task automatic push_normal();
    exp_q.push_back({8'h00, 32'h12345678});
    exp_q.push_back({8'h01, 32'h9ABCDEF0});
  endtask

  task automatic check_result(input string tag, input logic d, input logic [1:0] e, input logic h);
    repeat (2) @(negedge clk);
    check({tag, "_done"}, 32'(done), 32'(d));
    check({tag, "_err"}, 32'(err), 32'(e));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(h));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_rx_ready"}, 32'(rx_ready), 32'd0);
    check({tag, "_imem_we"}, 32'(imem_we), 32'd0);
    check({tag, "_imem_addr"}, 32'(imem_addr), 32'd0);
    check({tag, "_imem_wdata"}, imem_wdata, 32'd0);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin : stimulus
    logic [7:0] cs;
    logic [7:0] w0, w1, w2, w3;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd0);

    // normal load
    set_normal(8'h02);
    push_normal();
    pulse_start();
    check("start_busy", 32'(busy), 32'd1);
    check("start_rx_ready", 32'(rx_ready), 32'd1);
    send_all(0, 1'b0);
    check_result("normal", 1'b1, 2'b00, 1'b0);

    // bad checksum
    set_normal(8'h03);
    push_normal();
    pulse_start();
    send_all(0, 1'b0);
    check_result("badcsum", 1'b0, 2'b01, 1'b1);

    // length overflow: error on the cycle after LEN_LO, no writes
    stim = '{8'h01, 8'h01};
    pulse_start();
    send_all(0, 1'b0);
    check("ovf_err_next_cycle", 32'(err), 32'd2);
    check_result("ovf", 1'b0, 2'b10, 1'b1);

    // maximum legal length 0x100 covers addresses 0..255
    stim.delete();
    stim.push_back(8'h01);
    stim.push_back(8'h00);
    cs = 8'h01;
    for (int i = 0; i < 256; i++) begin
      w0 = 8'(i);
      w1 = ~8'(i);
      w2 = 8'(i + 1);
      w3 = 8'h3C;
      stim.push_back(w0);
      stim.push_back(w1);
      stim.push_back(w2);
      stim.push_back(w3);
      cs = cs ^ w0 ^ w1 ^ w2 ^ w3;
      exp_q.push_back({8'(i), w0, w1, w2, w3});
    end
    stim.push_back(cs);
    pulse_start();
    send_all(0, 1'b0);
    check_result("maxlen", 1'b1, 2'b00, 1'b0);

    // empty program
    stim = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    send_all(0, 1'b0);
    check_result("empty", 1'b1, 2'b00, 1'b0);

    // backpressure with a start pulse mid-load
    set_normal(8'h02);
    push_normal();
    pulse_start();
    send_all(5, 1'b1);
    check_result("gaps", 1'b1, 2'b00, 1'b0);

    // reset after five bytes
    set_normal(8'h02);
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(stim[i], 0);
    reset = 1'b0;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    push_normal();
    pulse_start();
    send_all(0, 1'b0);
    check_result("after_reset", 1'b1, 2'b00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. The program counter and decoder only read instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake, typically from a UART receiver or a test host.
- Assembles 32-bit instruction words big-endian and writes them to sequential instruction-memory addresses.
- Holds the processor in reset until a complete, checksum-verified program has been loaded.

Parameters:
ADDR_W, 8, instruction-memory word-address width; depth = 2**ADDR_W words
WORD_BYTES, 4, bytes per instruction word; fixed at 4 for the 32-bit ISA

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  single-cycle pulse; begins a new load from IDLE, DONE or ERR
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader can accept a byte
imem_we  output  1  instruction-memory write enable, single-cycle pulse
imem_addr  output  ADDR_W  word address for the write
imem_wdata  output  32  instruction word to write
cpu_hold  output  1  holds the processor (PC/regfile) in reset while high
busy  output  1  load in progress
done  output  1  level; last load completed with a good checksum
err  output  2  00 none, 01 checksum mismatch, 10 length overflow

Behaviour:
- Reset (async, reset=0): state IDLE. rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, busy=0, done=0, err=00, byte counter=0, word counter=0, xor accumulator=0. imem_we drops immediately on reset assertion.
- Handshake: a byte is consumed only on a clk edge with rx_valid=1 and rx_ready=1. rx_valid gaps of any length are allowed.
- rx_ready=1 only in states LEN_HI, LEN_LO, DATA, CSUM. rx_ready=0 in IDLE, DONE, ERR.
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, then one checksum byte.
- Checksum: 8-bit XOR of every byte from LEN_HI through the last data byte.
- IDLE/DONE/ERR + start: go to LEN_HI. Clear accumulator and counters, cpu_hold=1, busy=1, done=0, err=00.
- start while busy: ignored.
- LEN_HI: on handshake, capture the high byte and go to LEN_LO.
- LEN_LO: on handshake, form N and evaluate in this order:
  - N > 2**ADDR_W: go to ERR with err=10; no writes occur.
  - N = 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA:
  - Byte k of a word (k = 0..3) lands in bits [31-8k : 24-8k].
  - When the 4th byte is handshaken, imem_we=1 on the following cycle, with imem_addr = word index (starting at 0) and imem_wdata = assembled word.
  - rx_ready stays 1 during the write cycle, so there is no bubble.
  - After word N-1 is accepted, go to CSUM.
- CSUM:
  - Byte equals accumulator: go to DONE with done=1, busy=0, cpu_hold=0.
  - Otherwise: go to ERR with err=01, busy=0; cpu_hold stays 1.
  - Words already written are not rolled back.
- DONE/ERR: hold outputs until start or reset.
- Word index wrap is impossible, because N ≤ 2**ADDR_W is checked before any write. N = 2**ADDR_W is legal and writes addresses 0 through 2**ADDR_W-1.
- Simultaneous reset and handshake: reset wins; the byte is lost.

Decomposition:
- Shared package (processor package): loader state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERR), err code constants, INSTR_W=32.
- One sub-module, imem_word_packer: byte shift register plus 2-bit byte counter. Outputs word_valid for one cycle along with the assembled word.
- Top-level FSM owns the length, word counter, XOR accumulator and write register.

Test Plan:
- Normal load: bytes 00 02 12 34 56 78 9A BC DE F0 02 -> imem_we pulses with addr0=0x12345678 and addr1=0x9ABCDEF0; then done=1, err=00, cpu_hold=0.
- Bad checksum: same stream with final byte 03 -> both writes occur; err=01, done=0, cpu_hold=1, rx_ready=0.
- Overflow (ADDR_W=8): bytes 01 01 -> err=10 on the cycle after LEN_LO, imem_we never asserted. Length 01 00 is accepted.
- Empty program: bytes 00 00 00 -> done=1, no imem_we, cpu_hold=0.
- Backpressure: the normal-load stream with 0–5 random idle cycles between bytes -> identical writes and result; start pulsed mid-load has no effect.
- Reset mid-load: reset=0 after 5 bytes -> all outputs at reset values immediately. Then start plus the normal-load stream -> correct load and done=1.
